// File: rtl/processing_element_pkg.sv
// Shared configuration for the processing element slice.
//   PE_WIDTH_DEFAULT : default datapath width of one systolic cell
package processing_element_pkg;

  localparam int unsigned PE_WIDTH_DEFAULT = 8;

endpackage : processing_element_pkg

// File: rtl/pe_mac.sv
// Combinational multiply-add for one systolic cell, wrapped modulo 2^WIDTH.
//   weight   : stationary weight operand
//   west     : activation operand
//   ps       : partial sum from the north
//   ps_en    : high adds ps, low adds zero
//   mac_c    : low WIDTH bits of weight*west + (ps_en ? ps : 0)
module pe_mac
  import processing_element_pkg::*;
#(
  parameter int unsigned WIDTH = PE_WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] weight,
  input  logic [WIDTH-1:0] west,
  input  logic [WIDTH-1:0] ps,
  input  logic             ps_en,
  output logic [WIDTH-1:0] mac_c
);

  logic [WIDTH-1:0] addend_c;

  // The low WIDTH bits of a full-width product and sum equal those of the
  // same arithmetic carried out in WIDTH bits, so no wide intermediate is kept.
  always_comb begin
    addend_c = '0;
    if (ps_en) begin
      addend_c = ps;
    end
    mac_c = weight * west + addend_c;
  end

endmodule : pe_mac

// File: rtl/processing_element.sv
// Weight-stationary MAC cell, one pipeline stage of a systolic array.
//   clk_i          : clock, all state updates on rising edge
//   rstn_i         : asynchronous active-low reset
//   ctrl_load_i    : capture north_i as weight and pass it south (wins over sum)
//   ctrl_sum_out_i : drive MAC result south and into result_o
//   ctrl_ps_in_i   : add north_i as partial sum into the MAC
//   north_i        : weight (load) or partial sum (compute)
//   west_i         : activation from the left
//   east_o         : registered west_i
//   south_o        : registered pass-through or MAC result
//   weight_o       : current weight register
//   result_o       : last computed MAC result
module processing_element
  import processing_element_pkg::*;
#(
  parameter int unsigned WIDTH = PE_WIDTH_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             ctrl_load_i,
  input  logic             ctrl_sum_out_i,
  input  logic             ctrl_ps_in_i,
  input  logic [WIDTH-1:0] north_i,
  input  logic [WIDTH-1:0] west_i,
  output logic [WIDTH-1:0] east_o,
  output logic [WIDTH-1:0] south_o,
  output logic [WIDTH-1:0] weight_o,
  output logic [WIDTH-1:0] result_o
);

  logic [WIDTH-1:0] weight_q;
  logic [WIDTH-1:0] mac_c;

  // MAC always sees the weight held before the edge.
  pe_mac #(
    .WIDTH (WIDTH)
  ) u_mac (
    .weight (weight_q),
    .west   (west_i),
    .ps     (north_i),
    .ps_en  (ctrl_ps_in_i),
    .mac_c  (mac_c)
  );

  // Weight, result and south registers; load has priority over sum-out.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      weight_q <= '0;
      result_o <= '0;
      south_o  <= '0;
    end else if (ctrl_load_i) begin
      weight_q <= north_i;
      south_o  <= north_i;
    end else if (ctrl_sum_out_i) begin
      result_o <= mac_c;
      south_o  <= mac_c;
    end else begin
      south_o  <= north_i;
    end
  end

  // Activation forwarding is unconditional.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      east_o <= '0;
    end else begin
      east_o <= west_i;
    end
  end

  assign weight_o = weight_q;

endmodule : processing_element

// File: tb/tb_processing_element.sv
// Directed self-checking bench for processing_element (WIDTH=8).
module tb_processing_element;

  localparam int unsigned W = 8;

  logic         clk_i;
  logic         rstn_i;
  logic         ctrl_load_i;
  logic         ctrl_sum_out_i;
  logic         ctrl_ps_in_i;
  logic [W-1:0] north_i;
  logic [W-1:0] west_i;
  logic [W-1:0] east_o;
  logic [W-1:0] south_o;
  logic [W-1:0] weight_o;
  logic [W-1:0] result_o;

  int n_cmp;
  int n_bad;

  processing_element #(.WIDTH(W)) dut (
    .clk_i          (clk_i),
    .rstn_i         (rstn_i),
    .ctrl_load_i    (ctrl_load_i),
    .ctrl_sum_out_i (ctrl_sum_out_i),
    .ctrl_ps_in_i   (ctrl_ps_in_i),
    .north_i        (north_i),
    .west_i         (west_i),
    .east_o         (east_o),
    .south_o        (south_o),
    .weight_o       (weight_o),
    .result_o       (result_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Drive one cycle of inputs, then sample 1 time unit after the edge.
  task automatic cycle(input logic ld, input logic so, input logic ps,
                       input logic [W-1:0] n, input logic [W-1:0] w);
    ctrl_load_i    = ld;
    ctrl_sum_out_i = so;
    ctrl_ps_in_i   = ps;
    north_i        = n;
    west_i         = w;
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset;
    rstn_i = 1'b0;
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    n_cmp++;
    if ({east_o, south_o, weight_o, result_o} !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_init: got e=%h s=%h w=%h r=%h want all 00",
               east_o, south_o, weight_o, result_o);
    end
    rstn_i = 1'b1;
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic test_load;
    cycle(1'b1, 1'b0, 1'b0, 8'h03, 8'h00);
    n_cmp++;
    if (weight_o !== 8'h03 || south_o !== 8'h03 || result_o !== 8'h00) begin
      n_bad++;
      $display("FAIL load: got w=%h s=%h r=%h want w=03 s=03 r=00",
               weight_o, south_o, result_o);
    end
    cycle(1'b0, 1'b0, 1'b0, 8'h7F, 8'h00);
    n_cmp++;
    if (weight_o !== 8'h03 || south_o !== 8'h7F) begin
      n_bad++;
      $display("FAIL load_hold: got w=%h s=%h want w=03 s=7f", weight_o, south_o);
    end
  endtask

  task automatic test_mac;
    cycle(1'b0, 1'b1, 1'b1, 8'h0A, 8'h04);
    n_cmp++;
    if (south_o !== 8'h16 || result_o !== 8'h16) begin
      n_bad++;
      $display("FAIL mac_ps: got s=%h r=%h want 16", south_o, result_o);
    end
    cycle(1'b0, 1'b1, 1'b0, 8'h0A, 8'h04);
    n_cmp++;
    if (south_o !== 8'h0C || result_o !== 8'h0C) begin
      n_bad++;
      $display("FAIL mac_nops: got s=%h r=%h want 0c", south_o, result_o);
    end
  endtask

  task automatic test_overflow;
    cycle(1'b1, 1'b0, 1'b0, 8'h20, 8'h00);
    cycle(1'b0, 1'b1, 1'b1, 8'h05, 8'h10);
    n_cmp++;
    if (south_o !== 8'h05 || result_o !== 8'h05) begin
      n_bad++;
      $display("FAIL wrap_sum: got s=%h r=%h want 05", south_o, result_o);
    end
    cycle(1'b1, 1'b0, 1'b0, 8'hFF, 8'h00);
    cycle(1'b0, 1'b1, 1'b0, 8'h33, 8'hFF);
    n_cmp++;
    if (south_o !== 8'h01 || result_o !== 8'h01) begin
      n_bad++;
      $display("FAIL wrap_mul: got s=%h r=%h want 01", south_o, result_o);
    end
  endtask

  task automatic test_pass;
    logic [W-1:0] ramp [4];
    ramp = '{8'h11, 8'h22, 8'h33, 8'h44};
    cycle(1'b0, 1'b0, 1'b0, 8'h5A, 8'hA5);
    n_cmp++;
    if (south_o !== 8'h5A || east_o !== 8'hA5 || result_o !== 8'h01) begin
      n_bad++;
      $display("FAIL pass: got s=%h e=%h r=%h want s=5a e=a5 r=01",
               south_o, east_o, result_o);
    end
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 8'h00, ramp[i]);
      n_cmp++;
      if (east_o !== ramp[i]) begin
        n_bad++;
        $display("FAIL east_ramp[%0d]: got %h want %h", i, east_o, ramp[i]);
      end
    end
  endtask

  task automatic test_conflict;
    cycle(1'b1, 1'b1, 1'b1, 8'h09, 8'h07);
    n_cmp++;
    if (weight_o !== 8'h09 || south_o !== 8'h09 || result_o !== 8'h01) begin
      n_bad++;
      $display("FAIL load_vs_sum: got w=%h s=%h r=%h want w=09 s=09 r=01",
               weight_o, south_o, result_o);
    end
  endtask

  task automatic test_back_to_back;
    // New weight used the cycle after it is loaded, not before.
    cycle(1'b1, 1'b0, 1'b0, 8'h02, 8'h05);
    cycle(1'b0, 1'b1, 1'b0, 8'h00, 8'h05);
    n_cmp++;
    if (result_o !== 8'h0A || south_o !== 8'h0A) begin
      n_bad++;
      $display("FAIL weight_next_cycle: got s=%h r=%h want 0a", south_o, result_o);
    end
    cycle(1'b0, 1'b0, 1'b0, 8'hxx, 8'h00);
    n_cmp++;
    if (weight_o !== 8'h02) begin
      n_bad++;
      $display("FAIL weight_x_guard: got %h want 02", weight_o);
    end
  endtask

  task automatic test_reset_midstream;
    cycle(1'b0, 1'b1, 1'b1, 8'h10, 8'h03);
    rstn_i = 1'b0;
    #1;
    n_cmp++;
    if ({east_o, south_o, weight_o, result_o} !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_async: got e=%h s=%h w=%h r=%h want all 00",
               east_o, south_o, weight_o, result_o);
    end
    @(posedge clk_i);
    #1;
    rstn_i = 1'b1;
    cycle(1'b0, 1'b1, 1'b0, 8'h00, 8'h09);
    n_cmp++;
    if (result_o !== 8'h00 || weight_o !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_no_weight: got w=%h r=%h want 00", weight_o, result_o);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    ctrl_load_i = 1'b0;
    ctrl_sum_out_i = 1'b0;
    ctrl_ps_in_i = 1'b0;
    north_i = '0;
    west_i = '0;
    rstn_i = 1'b0;
    test_reset();
    test_load();
    test_mac();
    test_overflow();
    test_pass();
    test_conflict();
    test_back_to_back();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_processing_element
